// File: rtl/apple1_pkg.sv
// Shared encodings and address constants for the apple1 RAM loader slice.
package apple1_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StLoad,
      StFinish
   } ld_state_e;

   localparam logic [15:0] RomLo       = 16'hE000;
   localparam logic [15:0] DefaultBase = 16'h0280;
   localparam int unsigned SkidDepth   = 2;

   function automatic logic in_rom(input logic [15:0] addr, input logic [15:0] lo);
      return addr >= lo;
   endfunction

endpackage

// File: rtl/loader_skid_fifo.sv
// Two-entry byte FIFO absorbing ioctl strobes while the loader waits for the RAM port.
module loader_skid_fifo
   import apple1_pkg::*;
(
   input  logic       sys_clock,
   input  logic       reset_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   logic [7:0] mem_q [SkidDepth];
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] count_q;
   logic       push_ok, pop_ok;

   assign full  = (count_q == 2'(SkidDepth));
   assign empty = (count_q == 2'd0);
   assign rdata = mem_q[rd_ptr_q];

   // A simultaneous pop frees a slot, so a push into a full FIFO is still taken.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < SkidDepth; i++) mem_q[i] <= 8'h00;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
      end
   end

endmodule

// File: rtl/ram_loader.sv
// RAM-port arbiter between the apple1 core and main memory; loads host images via ioctl.
module ram_loader
   import apple1_pkg::*;
#(
   parameter bit          HEADER_EN    = 1'b1,
   parameter logic [15:0] DEFAULT_BASE = DefaultBase,
   parameter logic [15:0] ROM_LO       = RomLo,
   parameter bit          ROM_WP       = 1'b1,
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic        sys_clock,
   input  logic        reset_n,
   input  logic        cpu_clken,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_dout,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_data,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   input  logic [7:0]  mem_dout,
   output logic        cpu_hold,
   output logic        reset_req,
   output logic        load_done,
   output logic        load_err
);

   ld_state_e   state_q, state_d;
   logic        dl_q;
   logic [16:0] cnt_q;
   logic [15:0] base_q;
   logic        wr_q;
   logic [15:0] wr_addr_q;
   logic [7:0]  wr_data_q;
   logic [15:0] rst_cnt_q;
   logic        load_done_q, load_err_q;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        dl_rise, dl_end, has_data, is_data, overflow, loading;
   logic [15:0] load_addr;

   // The core's RAM select carries no information the write strobe does not already give.
   logic unused_cpu_rd;
   assign unused_cpu_rd = cpu_rd;

   loader_skid_fifo u_fifo (
      .sys_clock (sys_clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .wdata     (ioctl_data),
      .rdata     (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign loading   = (state_q == StDrain) | (state_q == StLoad);
   assign dl_rise   = ioctl_download & ~dl_q;
   assign dl_end    = ~ioctl_download & fifo_empty;
   assign fifo_push = ioctl_wr & loading;
   assign fifo_pop  = (state_q == StLoad) & ~fifo_empty;
   assign overflow  = fifo_push & fifo_full & ~fifo_pop;
   assign has_data  = HEADER_EN ? (cnt_q > 17'd2) : (cnt_q != 17'd0);
   assign is_data   = ~HEADER_EN | (cnt_q >= 17'd2);
   assign load_addr = HEADER_EN ? (base_q + cnt_q[15:0] - 16'd2)
                                : (DEFAULT_BASE + cnt_q[15:0]);

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         dl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dl_q    <= ioctl_download;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (dl_rise) state_d = StDrain;
         StDrain: begin
            if (dl_end)         state_d = has_data ? StFinish : StIdle;
            else if (cpu_clken) state_d = StLoad;
         end
         StLoad:   if (dl_end) state_d = has_data ? StFinish : StIdle;
         StFinish: if (rst_cnt_q == 16'(RESET_CYCLES - 1)) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= 17'd0;
         base_q      <= DEFAULT_BASE;
         wr_q        <= 1'b0;
         wr_addr_q   <= 16'h0000;
         wr_data_q   <= 8'h00;
         rst_cnt_q   <= 16'd0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         if ((state_q == StIdle) && dl_rise) begin
            cnt_q      <= 17'd0;
            load_err_q <= 1'b0;
         end else begin
            if (fifo_pop && (cnt_q != '1)) cnt_q <= cnt_q + 17'd1;
            if (overflow || (loading && dl_end && !has_data)) load_err_q <= 1'b1;
         end
         if (fifo_pop && HEADER_EN && (cnt_q == 17'd0)) base_q[7:0]  <= fifo_rdata;
         if (fifo_pop && HEADER_EN && (cnt_q == 17'd1)) base_q[15:8] <= fifo_rdata;
         // Pops are turned into a registered one-cycle write on the following cycle.
         wr_q        <= fifo_pop & is_data;
         wr_addr_q   <= load_addr;
         wr_data_q   <= fifo_rdata;
         rst_cnt_q   <= (state_q == StFinish) ? rst_cnt_q + 16'd1 : 16'd0;
         load_done_q <= (state_d == StFinish) && (state_q != StFinish);
      end
   end

   always_comb begin
      cpu_dout  = mem_dout;
      cpu_hold  = (state_q != StIdle);
      reset_req = (state_q == StFinish);
      load_done = load_done_q;
      load_err  = load_err_q;
      mem_addr  = cpu_addr;
      mem_din   = cpu_din;
      mem_we    = cpu_wr & ~(ROM_WP & in_rom(cpu_addr, ROM_LO));
      if ((state_q == StLoad) || (state_q == StFinish)) begin
         mem_addr = wr_addr_q;
         mem_din  = wr_data_q;
         mem_we   = wr_q;
      end
   end

endmodule
